// File: rtl/b06_irq_arbiter_if.sv
// rtl/b06_irq_arbiter_if.sv - requester and handler signal bundle for b06_irq_arbiter
// Ports (signals):
//   req, done          requester level request / service-complete pulse
//   uscite, ackout     b06 handler status and acknowledge
//   eql, cont_eql      drives to the b06 handler inputs
//   grant, grant_id    one-hot grant and index of current or last grantee
//   busy, timeout_err  arbiter activity and one-cycle handshake timeout pulse
// Modports: master = arbiter side, slave = requesters/handler side.
interface b06_irq_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic [1:0]      uscite;
    logic            ackout;
    logic            eql;
    logic            cont_eql;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            busy;
    logic            timeout_err;

    modport master (
        input  req, done, uscite, ackout,
        output eql, cont_eql, grant, grant_id, busy, timeout_err
    );

    modport slave (
        output req, done, uscite, ackout,
        input  eql, cont_eql, grant, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/b06_irq_arbiter.sv
// rtl/b06_irq_arbiter.sv - round-robin arbiter sharing one b06 interrupt handler
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      b06_irq_arbiter_if.master (requests, handler handshake, grant outputs)
module b06_irq_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int HOLD_MAX = 15
) (
    input logic                 clock,
    input logic                 reset_n,
    b06_irq_arbiter_if.master   bus
);
    localparam int TW = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVE   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            eql_q, eql_d;
    logic            cont_eql_q, cont_eql_d;
    logic            busy_q, busy_d;
    logic            timeout_err_q, timeout_err_d;

    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic            tmo_hit;
    logic            engaged;
    logic            svc_end;

    // rr_ptr and grant_id are always below NREQ, so a single conditional
    // subtract is enough to wrap (v < 2*NREQ).
    function automatic logic [IDW-1:0] wrap_idx(input int v);
        if (v >= NREQ) return IDW'(v - NREQ);
        else           return IDW'(v);
    endfunction

    // Round-robin search starting at rr_ptr; first set req bit wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && bus.req[wrap_idx(int'(rr_ptr_q) + i)]) begin
                win_found = 1'b1;
                win_id    = wrap_idx(int'(rr_ptr_q) + i);
            end
        end
    end

    assign tmo_hit = (tmo_cnt_q == TW'(HOLD_MAX));
    assign engaged = (bus.uscite == 2'b00);
    // Only the granted line may end service; grant is one-hot so masking with
    // it avoids indexing by grant_id.
    assign svc_end = (|(bus.done & grant_q)) || !(|(bus.req & grant_q));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:    state_d = win_found ? S_ASSERT : S_IDLE;
            S_ASSERT:  state_d = engaged ? S_SERVE : (tmo_hit ? S_RELEASE : S_ASSERT);
            S_SERVE:   state_d = svc_end ? S_RELEASE : S_SERVE;
            S_RELEASE: state_d = (bus.ackout || tmo_hit) ? S_IDLE : S_RELEASE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        tmo_cnt_d     = tmo_cnt_q;
        eql_d         = eql_q;
        cont_eql_d    = cont_eql_q;
        busy_d        = busy_q;
        timeout_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d    = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
                    grant_id_d = win_id;
                    eql_d      = 1'b1;
                    cont_eql_d = 1'b1;
                    busy_d     = 1'b1;
                    tmo_cnt_d  = '0;
                end
            end
            S_ASSERT: begin
                if (!engaged) begin
                    if (tmo_hit) begin
                        timeout_err_d = 1'b1;
                        eql_d         = 1'b0;
                        cont_eql_d    = 1'b0;
                        // RELEASE gets its own full window
                        tmo_cnt_d     = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end
                end
            end
            S_SERVE: begin
                if (svc_end) begin
                    eql_d      = 1'b0;
                    cont_eql_d = 1'b0;
                    tmo_cnt_d  = '0;
                end
            end
            S_RELEASE: begin
                if (bus.ackout || tmo_hit) begin
                    timeout_err_d = !bus.ackout;
                    grant_d       = '0;
                    cont_eql_d    = 1'b1;
                    busy_d        = 1'b0;
                    tmo_cnt_d     = '0;
                    rr_ptr_d      = wrap_idx(int'(grant_id_q) + 1);
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            default: begin
                grant_d    = '0;
                grant_id_d = '0;
                rr_ptr_d   = '0;
                tmo_cnt_d  = '0;
                eql_d      = 1'b0;
                cont_eql_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_q       <= '0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            tmo_cnt_q     <= '0;
            eql_q         <= 1'b0;
            cont_eql_q    <= 1'b1;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            tmo_cnt_q     <= tmo_cnt_d;
            eql_q         <= eql_d;
            cont_eql_q    <= cont_eql_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.eql         = eql_q;
    assign bus.cont_eql    = cont_eql_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_b06_irq_arbiter.sv
// tb/tb_b06_irq_arbiter.sv - directed vector bench for b06_irq_arbiter
module tb_b06_irq_arbiter;
    logic clock;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    b06_irq_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

    b06_irq_arbiter #(.NREQ(4), .IDW(2), .HOLD_MAX(15)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [1:0] us;
        logic       ack;
        logic [9:0] exp;
    } vec_t;

    vec_t vt[$];

    // {grant, grant_id, eql, cont_eql, busy, timeout_err}
    function automatic logic [9:0] pk(input logic [3:0] g, input logic [1:0] id,
                                      input logic e, input logic c,
                                      input logic b, input logic t);
        return {g, id, e, c, b, t};
    endfunction

    function automatic void addv(input logic [3:0] r, input logic [3:0] d,
                                 input logic [1:0] u, input logic a,
                                 input logic [9:0] x);
        vec_t v;
        v.req = r; v.done = d; v.us = u; v.ack = a; v.exp = x;
        vt.push_back(v);
    endfunction

    function automatic logic [9:0] outs();
        return {bus.grant, bus.grant_id, bus.eql, bus.cont_eql, bus.busy, bus.timeout_err};
    endfunction

    task automatic chk(input string nm, input logic [9:0] x);
        logic [9:0] a;
        a = outs();
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got g=%b id=%0d eql=%b cont=%b busy=%b terr=%b, want g=%b id=%0d eql=%b cont=%b busy=%b terr=%b",
                     nm, a[9:6], a[5:4], a[3], a[2], a[1], a[0],
                     x[9:6], x[5:4], x[3], x[2], x[1], x[0]);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] d,
                        input logic [1:0] u, input logic a);
        @(negedge clock);
        bus.req = r; bus.done = d; bus.uscite = u; bus.ackout = a;
        @(posedge clock);
        #1;
    endtask

    // Runs n idle-handshake cycles and counts any cycle whose outputs leave x.
    task automatic hold(input int n, input logic [3:0] r, input logic [9:0] x,
                        output int dev);
        dev = 0;
        for (int k = 0; k < n; k++) begin
            step(r, 4'b0000, 2'b01, 1'b0);
            if (outs() !== x) dev++;
        end
    endtask

    initial begin
        int dev;
        reset_n = 1'b0;
        bus.req = '0; bus.done = '0; bus.uscite = 2'b01; bus.ackout = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", pk(4'b0000, 2'd0, 0, 1, 0, 0));
        @(negedge clock);
        reset_n = 1'b1;

        // single requester
        addv(4'b0001, 4'b0000, 2'b01, 0, pk(4'b0001, 2'd0, 1, 1, 1, 0));
        addv(4'b0001, 4'b0000, 2'b01, 0, pk(4'b0001, 2'd0, 1, 1, 1, 0));
        addv(4'b0001, 4'b0000, 2'b00, 0, pk(4'b0001, 2'd0, 1, 1, 1, 0));
        addv(4'b0001, 4'b0000, 2'b00, 0, pk(4'b0001, 2'd0, 1, 1, 1, 0));
        addv(4'b0001, 4'b0001, 2'b00, 0, pk(4'b0001, 2'd0, 0, 0, 1, 0));
        addv(4'b0001, 4'b0000, 2'b01, 0, pk(4'b0001, 2'd0, 0, 0, 1, 0));
        addv(4'b0001, 4'b0000, 2'b01, 1, pk(4'b0000, 2'd0, 0, 1, 0, 0));
        // round-robin: rr_ptr = 1 now
        addv(4'b1111, 4'b0000, 2'b01, 0, pk(4'b0010, 2'd1, 1, 1, 1, 0));
        addv(4'b1111, 4'b0000, 2'b00, 0, pk(4'b0010, 2'd1, 1, 1, 1, 0));
        addv(4'b1111, 4'b0010, 2'b00, 0, pk(4'b0010, 2'd1, 0, 0, 1, 0));
        addv(4'b1111, 4'b0000, 2'b01, 1, pk(4'b0000, 2'd1, 0, 1, 0, 0));
        addv(4'b1111, 4'b0000, 2'b01, 0, pk(4'b0100, 2'd2, 1, 1, 1, 0));
        addv(4'b1111, 4'b0000, 2'b00, 0, pk(4'b0100, 2'd2, 1, 1, 1, 0));
        // early request drop ends service
        addv(4'b1011, 4'b0000, 2'b00, 0, pk(4'b0100, 2'd2, 0, 0, 1, 0));
        addv(4'b1011, 4'b0000, 2'b01, 1, pk(4'b0000, 2'd2, 0, 1, 0, 0));
        // wrap priority from rr_ptr = 3
        addv(4'b1001, 4'b0000, 2'b01, 0, pk(4'b1000, 2'd3, 1, 1, 1, 0));
        addv(4'b1001, 4'b0001, 2'b00, 0, pk(4'b1000, 2'd3, 1, 1, 1, 0));
        addv(4'b1001, 4'b0001, 2'b00, 0, pk(4'b1000, 2'd3, 1, 1, 1, 0));
        addv(4'b1001, 4'b1000, 2'b00, 0, pk(4'b1000, 2'd3, 0, 0, 1, 0));
        addv(4'b1001, 4'b0000, 2'b01, 1, pk(4'b0000, 2'd3, 0, 1, 0, 0));
        addv(4'b1001, 4'b0000, 2'b01, 0, pk(4'b0001, 2'd0, 1, 1, 1, 0));
        // done together with engagement is dropped
        addv(4'b1001, 4'b0001, 2'b00, 0, pk(4'b0001, 2'd0, 1, 1, 1, 0));
        addv(4'b1001, 4'b0000, 2'b00, 0, pk(4'b0001, 2'd0, 1, 1, 1, 0));
        addv(4'b1001, 4'b0001, 2'b00, 0, pk(4'b0001, 2'd0, 0, 0, 1, 0));
        addv(4'b0000, 4'b0000, 2'b01, 1, pk(4'b0000, 2'd0, 0, 1, 0, 0));
        addv(4'b0000, 4'b0000, 2'b01, 0, pk(4'b0000, 2'd0, 0, 1, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].req, vt[i].done, vt[i].us, vt[i].ack);
            chk($sformatf("vec%0d", i), vt[i].exp);
        end

        // ASSERT timeout, rr_ptr = 1
        step(4'b0010, 4'b0000, 2'b01, 0);
        chk("tmo_a_grant", pk(4'b0010, 2'd1, 1, 1, 1, 0));
        hold(15, 4'b0010, pk(4'b0010, 2'd1, 1, 1, 1, 0), dev);
        total++;
        if (dev != 0) begin
            bad++;
            $display("FAIL tmo_a_hold: deviating cycles=%0d, want 0", dev);
        end
        step(4'b0010, 4'b0000, 2'b01, 0);
        chk("tmo_a_pulse", pk(4'b0010, 2'd1, 0, 0, 1, 1));
        step(4'b0010, 4'b0000, 2'b01, 0);
        chk("tmo_a_rel", pk(4'b0010, 2'd1, 0, 0, 1, 0));
        step(4'b0010, 4'b0000, 2'b01, 1);
        chk("tmo_a_idle", pk(4'b0000, 2'd1, 0, 1, 0, 0));

        // RELEASE timeout after early drop, rr_ptr = 2
        step(4'b0010, 4'b0000, 2'b01, 0);
        chk("tmo_r_grant", pk(4'b0010, 2'd1, 1, 1, 1, 0));
        step(4'b0010, 4'b0000, 2'b00, 0);
        chk("tmo_r_serve", pk(4'b0010, 2'd1, 1, 1, 1, 0));
        step(4'b0001, 4'b0000, 2'b00, 0);
        chk("tmo_r_drop", pk(4'b0010, 2'd1, 0, 0, 1, 0));
        hold(15, 4'b0001, pk(4'b0010, 2'd1, 0, 0, 1, 0), dev);
        total++;
        if (dev != 0) begin
            bad++;
            $display("FAIL tmo_r_hold: deviating cycles=%0d, want 0", dev);
        end
        step(4'b0001, 4'b0000, 2'b01, 0);
        chk("tmo_r_pulse", pk(4'b0000, 2'd1, 0, 1, 0, 1));
        step(4'b0001, 4'b0000, 2'b01, 0);
        chk("tmo_r_next", pk(4'b0001, 2'd0, 1, 1, 1, 0));
        step(4'b0001, 4'b0000, 2'b00, 0);
        step(4'b0001, 4'b0001, 2'b00, 0);
        chk("svc0_rel", pk(4'b0001, 2'd0, 0, 0, 1, 0));
        step(4'b0000, 4'b0000, 2'b01, 1);
        chk("svc0_idle", pk(4'b0000, 2'd0, 0, 1, 0, 0));

        // reset in the middle of SERVE
        step(4'b1000, 4'b0000, 2'b01, 0);
        chk("rst_grant3", pk(4'b1000, 2'd3, 1, 1, 1, 0));
        step(4'b1000, 4'b0000, 2'b00, 0);
        @(negedge clock);
        reset_n = 1'b0;
        bus.req = '0; bus.done = '0; bus.uscite = 2'b01; bus.ackout = 1'b0;
        #1;
        chk("rst_mid_serve", pk(4'b0000, 2'd0, 0, 1, 0, 0));
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step(4'b0000, 4'b0000, 2'b01, 0);
        chk("rst_idle", pk(4'b0000, 2'd0, 0, 1, 0, 0));
        step(4'b1111, 4'b0000, 2'b01, 0);
        chk("rst_rr_ptr", pk(4'b0001, 2'd0, 1, 1, 1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/b06_irq_arbiter.md
Name: b06_irq_arbiter

Overview:
- Shares one b06 interrupt handler between NREQ requesters.
- Round-robin selects one pending request, drives the handler's eql/cont_eql inputs to run one service cycle, and watches handler outputs uscite/ackout for engagement and completion.
- Grants exactly one requester at a time; the grant stays held until the requester finishes or the handler times out.
- Sits between the interrupt sources and the b06 instance. eql/cont_eql outputs connect directly to the handler inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of grant_id; must be ≥ clog2(NREQ).
- HOLD_MAX, 15, cycles allowed in ASSERT or RELEASE before timeout (1..255).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester level request.
- done  in  NREQ  per-requester single-cycle service-complete pulse.
- uscite  in  2  handler status (00 = engaged, 01 = waiting, 11 = interrupt wait).
- ackout  in  1  handler acknowledge.
- eql  out  1  to handler eql.
- cont_eql  out  1  to handler cont_eql.
- grant  out  NREQ  one-hot grant; all zeros when idle.
- grant_id  out  IDW  index of the current or last grantee.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  one-cycle pulse on handshake timeout.

Behaviour:
- All outputs are registered.
- Reset values: grant = 0, grant_id = 0, eql = 0, cont_eql = 1, busy = 0, timeout_err = 0, rr_ptr = 0, tmo_cnt = 0, state = IDLE. Reset takes effect immediately on assertion and aborts any service in progress.
- Round-robin: search starts at rr_ptr and wraps from NREQ-1 to 0; the first set req bit wins. After RELEASE completes, rr_ptr = (grant_id + 1) mod NREQ. rr_ptr also advances this way on timeout.
- IDLE:
  - If |req: on the same edge latch grant/grant_id to the winner, eql <= 1, busy <= 1, tmo_cnt <= 0, go to ASSERT.
  - Latency: req high at edge N gives grant high after edge N.
- ASSERT (eql = 1, cont_eql = 1):
  - If uscite == 00: go to SERVE.
  - Else tmo_cnt increments. When tmo_cnt == HOLD_MAX: timeout_err pulses for 1 cycle, eql <= 0, go to RELEASE.
- SERVE (eql = 1, cont_eql = 1), no timeout:
  - If done[grant_id] or !req[grant_id]: eql <= 0, cont_eql <= 0, tmo_cnt <= 0, go to RELEASE.
  - done or req changes on non-granted lines are ignored.
- RELEASE (eql = 0, cont_eql = 0):
  - If ackout == 1: grant <= 0, cont_eql <= 1, busy <= 0, update rr_ptr, go to IDLE. grant_id keeps its value.
  - Else tmo_cnt increments. At HOLD_MAX: timeout_err pulses for 1 cycle, then the IDLE transition is forced as above.
- Minimum service: 1 cycle IDLE→ASSERT, 1 or more in ASSERT, 1 or more in SERVE, 1 or more in RELEASE. The grant is low for at least 1 cycle between consecutive grants, because the next arbitration happens from IDLE.
- Simultaneous events:
  - done and uscite == 00 in the same ASSERT cycle: the engagement is taken first (go to SERVE); done is not remembered.
  - req deasserted during ASSERT: ignored until SERVE.
  - A new req arriving while busy waits for the next IDLE arbitration.
- Illegal state encodings recover to IDLE with reset output values on the next edge.
- tmo_cnt width is ceil(log2(HOLD_MAX+1)) and saturates; it never wraps.
- No X propagation: a req bit set at or beyond NREQ is impossible by construction.

Test Plan:
- Reset/idle: assert reset_n = 0 mid-SERVE → same cycle grant = 0, eql = 0, cont_eql = 1, busy = 0. After release with req = 0: all outputs hold their reset values.
- Single requester: req = 0001, handler model returns uscite = 00 two cycles after eql, done[0] pulses 5 cycles later, ackout = 1 one cycle into RELEASE → grant = 0001 for the whole sequence, ASSERT→SERVE→RELEASE→IDLE, rr_ptr = 1.
- Round-robin fairness: req = 1111 held, handler model cooperates → grant order 0001, 0010, 0100, 1000, 0001, with ≥1 idle cycle between each grant.
- Wrap priority: rr_ptr = 3 after serving req2, then req = 1001 → grant = 1000 first, then 0001.
- ASSERT timeout: HOLD_MAX = 15, uscite stuck at 01 → timeout_err pulses on the 16th ASSERT cycle, eql drops, then RELEASE proceeds normally.
- RELEASE timeout plus early drop: req[1] drops in SERVE and ackout stays 0 → RELEASE is entered, then at HOLD_MAX timeout_err pulses, grant clears, busy = 0, and the next pending req is granted.
